// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered ALU among NUM_REQ clients.
// Optional ALU_ARB_STATS_EN adds a saturating completed-response counter op_count.
module alu_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int RES_WIDTH = 2*WIDTH,
  parameter int IDW       = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_opcode,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic [1:0]               alu_opcode,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  input  logic [RES_WIDTH-1:0]     alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [RES_WIDTH-1:0]     rsp_result
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]              op_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPT,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   hi_g;
  logic [IDW-1:0]   lo_g;
  logic             hi_hit;
  logic             found;
  logic             accept;
  logic             rsp_done;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Lowest valid index above last_grant, else lowest valid overall (wrap).
  always_comb begin
    hi_hit = 1'b0;
    found  = 1'b0;
    hi_g   = '0;
    lo_g   = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found = 1'b1;
        lo_g  = IDW'(i);
        if (IDW'(i) > last_grant) begin
          hi_hit = 1'b1;
          hi_g   = IDW'(i);
        end
      end
    end
    grant = hi_hit ? hi_g : lo_g;
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == grant) begin
        sel_op = req_opcode[2*i +: 2];
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  assign accept   = (state == IDLE) && found;
  assign rsp_done = rsp_valid && rsp_ready;

  always_comb begin
    req_ready = '0;
    if (accept && !rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (IDW'(i) == grant) req_ready[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (found)     state_nx = EXEC;
      EXEC:                state_nx = CAPT;
      CAPT:                state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      last_grant <= IDW'(NUM_REQ-1);
    end else begin
      if (accept) begin
        alu_opcode <= sel_op;
        alu_a      <= sel_a;
        alu_b      <= sel_b;
        rsp_id     <= grant;
        last_grant <= grant;
      end
      if (state == CAPT) begin
        rsp_result <= alu_result;
        rsp_valid  <= 1'b1;
      end
      if (state == RESP && rsp_done) rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             op_count <= '0;
    else if (rsp_done && op_count != '1) op_count <= op_count + 16'd1;
  end
`endif

endmodule
